// File: rtl/qsn_shift_scheduler_pkg.sv
// Shared types and constants for the QSN shift scheduler: geometry of the
// base matrix, the null-submatrix marker and the scheduler state encoding.
package qsn_sched_pkg;

    localparam int PERMUTATION_LENGTH = 15;
    localparam int SHIFT_W            = $clog2(PERMUTATION_LENGTH);
    localparam int LAYER_NUM          = 4;
    localparam int COL_NUM            = 8;
    localparam int ITER_W             = 4;

    localparam int ENTRY_NUM = LAYER_NUM * COL_NUM;
    localparam int ADDR_W    = $clog2(ENTRY_NUM);
    localparam int LAYER_W   = $clog2(LAYER_NUM);
    localparam int COL_W     = $clog2(COL_NUM);

    typedef logic [SHIFT_W-1:0] shift_t;

    localparam shift_t NULL_SHIFT = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } sched_state_e;

    // Flat table index of a (layer, column) slot.
    function automatic logic [ADDR_W-1:0] slot_addr(input logic [LAYER_W-1:0] layer,
                                                    input logic [COL_W-1:0]   col);
        return ADDR_W'(int'(layer) * COL_NUM + int'(col));
    endfunction

endpackage

// File: rtl/qsn_shift_scheduler_if.sv
// Shift-factor stream from the scheduler to the QSN controller, with the
// slot tags that travel alongside each shift.
interface qsn_shift_scheduler_if;
    import qsn_sched_pkg::*;

    logic                 out_valid;
    logic                 out_ready;
    shift_t               shift_factor;
    logic [LAYER_W-1:0]   layer_idx;
    logic [COL_W-1:0]     col_idx;
    logic [ITER_W-1:0]    iter_idx;
    logic                 flush;

    modport master (
        output out_valid, shift_factor, layer_idx, col_idx, iter_idx, flush,
        input  out_ready
    );

    modport slave (
        input  out_valid, shift_factor, layer_idx, col_idx, iter_idx, flush,
        output out_ready
    );

endinterface

// File: rtl/qsn_shift_delta_modp.sv
// Combinational (a - b) mod Pc for operands already in 0..Pc-1; used both for
// relative shifts (a = target, b = stored rotation) and restoring shifts (a = 0).
module qsn_shift_delta_modp
    import qsn_sched_pkg::*;
(
    input  shift_t a,
    input  shift_t b,
    output shift_t diff
);

    localparam logic [SHIFT_W:0] PC_EXT = (SHIFT_W + 1)'(PERMUTATION_LENGTH);

    // One extra bit keeps a + Pc - b from overflowing before truncation.
    logic [SHIFT_W:0] wrap_sum;

    assign wrap_sum = {1'b0, a} + PC_EXT - {1'b0, b};

    // NOTE: combinational outputs get a default first so no path leaves them unassigned and infers a latch.
    always_comb begin
        diff = '0;
        if (a >= b) begin
            diff = a - b;
        end else begin
            diff = wrap_sum[SHIFT_W-1:0];
        end
    end

endmodule

// File: rtl/qsn_shift_scheduler.sv
// Walks a programmable base-matrix shift table and issues rotation-relative
// shifts to the QSN controller, then restoring shifts so columns end unrotated.
module qsn_shift_scheduler
    import qsn_sched_pkg::*;
(
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [ADDR_W-1:0]    cfg_addr,
    input  shift_t               cfg_data,
    input  logic                 start,
    input  logic [ITER_W-1:0]    iter_num,
    qsn_shift_scheduler_if.master shift_bus,
    output logic                 busy,
    output logic                 done
);

    sched_state_e        state_q;
    sched_state_e        nxt_state;
    logic [ITER_W-1:0]   iter_last_q;
    shift_t              table_q [ENTRY_NUM];
    shift_t              rot_q   [COL_NUM];

    logic [LAYER_W-1:0]  nxt_layer;
    logic [COL_W-1:0]    nxt_col;
    logic [ITER_W-1:0]   nxt_iter;
    logic [ADDR_W-1:0]   nxt_addr;
    logic [ADDR_W-1:0]   cur_addr;
    shift_t              nxt_entry;
    shift_t              nxt_rot;
    shift_t              delta_a;
    shift_t              delta;
    logic                nxt_valid;
    logic                nxt_active;

    logic                addr_ok;
    logic                cfg_write;
    logic                cfg_hit;
    logic                accept;
    logic                advance;
    logic                load;

    generate
        if (ENTRY_NUM == (1 << ADDR_W)) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_partial
            assign addr_ok = 32'(cfg_addr) < ENTRY_NUM;
        end
    endgenerate

    assign cfg_write = (state_q == IDLE) && cfg_we && addr_ok;
    assign cur_addr  = slot_addr(shift_bus.layer_idx, shift_bus.col_idx);
    assign accept    = shift_bus.out_valid && shift_bus.out_ready;
    assign advance   = ((state_q == RUN) || (state_q == FLUSH))
                       && (!shift_bus.out_valid || shift_bus.out_ready);
    assign load      = ((state_q == IDLE) && start) || advance;

    // NOTE: the shift table has no reset; its contents survive rst and are only rewritten through cfg_we.
    always_ff @(posedge sys_clk) begin
        if (cfg_write) begin
            table_q[cfg_addr] <= cfg_data;
        end
    end

    // Slot that becomes current on the next load; the output tags double as the scan pointer.
    always_comb begin
        nxt_state = state_q;
        nxt_layer = shift_bus.layer_idx;
        nxt_col   = shift_bus.col_idx;
        nxt_iter  = shift_bus.iter_idx;
        unique case (state_q)
            IDLE: begin
                nxt_state = RUN;
                nxt_layer = '0;
                nxt_col   = '0;
                nxt_iter  = '0;
            end
            RUN: begin
                if (shift_bus.col_idx != COL_W'(COL_NUM - 1)) begin
                    nxt_col = shift_bus.col_idx + COL_W'(1);
                end else begin
                    nxt_col = '0;
                    if (shift_bus.layer_idx != LAYER_W'(LAYER_NUM - 1)) begin
                        nxt_layer = shift_bus.layer_idx + LAYER_W'(1);
                    end else begin
                        nxt_layer = '0;
                        if (shift_bus.iter_idx == iter_last_q) begin
                            nxt_state = FLUSH;
                        end else begin
                            nxt_iter = shift_bus.iter_idx + ITER_W'(1);
                        end
                    end
                end
            end
            FLUSH: begin
                if (shift_bus.col_idx == COL_W'(COL_NUM - 1)) begin
                    nxt_state = DONE;
                    nxt_col   = '0;
                    nxt_iter  = '0;
                end else begin
                    nxt_col = shift_bus.col_idx + COL_W'(1);
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // A write landing together with start must already be seen by the first slot.
    assign nxt_addr   = slot_addr(nxt_layer, nxt_col);
    assign cfg_hit    = cfg_write && (cfg_addr == nxt_addr);
    assign nxt_entry  = cfg_hit ? cfg_data : table_q[nxt_addr];
    assign nxt_rot    = rot_q[nxt_col];
    assign delta_a    = (nxt_state == FLUSH) ? '0 : nxt_entry;
    assign nxt_active = (nxt_state == RUN) || (nxt_state == FLUSH);

    always_comb begin
        nxt_valid = 1'b0;
        if (nxt_state == RUN) begin
            nxt_valid = (nxt_entry != NULL_SHIFT);
        end else if (nxt_state == FLUSH) begin
            nxt_valid = (nxt_rot != '0);
        end
    end

    qsn_shift_delta_modp u_delta (
        .a    (delta_a),
        .b    (nxt_rot),
        .diff (delta)
    );

    // NOTE: every register here uses <= so all updates see pre-edge values, regardless of statement order.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q                <= IDLE;
            iter_last_q            <= '0;
            rot_q                  <= '{default: '0};
            shift_bus.out_valid    <= 1'b0;
            shift_bus.shift_factor <= '0;
            shift_bus.layer_idx    <= '0;
            shift_bus.col_idx      <= '0;
            shift_bus.iter_idx     <= '0;
            shift_bus.flush        <= 1'b0;
            busy                   <= 1'b0;
            done                   <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                rot_q <= '{default: '0};
                if (start) begin
                    iter_last_q <= (iter_num == '0) ? '0 : iter_num - ITER_W'(1);
                end
            end

            // Next slot of this column is at least COL_NUM cycles away, so no forwarding.
            if (accept) begin
                rot_q[shift_bus.col_idx] <= (state_q == RUN) ? table_q[cur_addr] : '0;
            end

            if (load) begin
                state_q                <= nxt_state;
                shift_bus.out_valid    <= nxt_valid;
                shift_bus.shift_factor <= nxt_active ? delta : '0;
                shift_bus.layer_idx    <= nxt_layer;
                shift_bus.col_idx      <= nxt_col;
                shift_bus.iter_idx     <= nxt_iter;
                shift_bus.flush        <= (nxt_state == FLUSH);
                busy                   <= nxt_active;
                done                   <= (nxt_state == DONE);
            end else if (state_q == DONE) begin
                state_q <= IDLE;
                done    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_qsn_shift_scheduler.sv
// Directed bench for qsn_shift_scheduler: hand-computed shift sequences, a
// small reference walk of the table, backpressure, mid-run config and reset.
module tb_qsn_shift_scheduler;

    typedef struct packed {
        logic [3:0] sf;
        logic [1:0] layer;
        logic [2:0] col;
        logic [3:0] iter;
        logic       flush;
    } ent_t;

    logic       sys_clk = 1'b0;
    logic       rst     = 1'b1;
    logic       cfg_we  = 1'b0;
    logic [4:0] cfg_addr = '0;
    logic [3:0] cfg_data = '0;
    logic       start   = 1'b0;
    logic [3:0] iter_num = '0;
    logic       busy;
    logic       done;

    qsn_shift_scheduler_if bus ();

    qsn_shift_scheduler dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .start     (start),
        .iter_num  (iter_num),
        .shift_bus (bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 sys_clk = ~sys_clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   tm [32];
    ent_t acc [$];
    ent_t exp_q [$];
    int   max_iter;
    bit   any_valid;
    int   stab_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic ent_t mk(input int sf, input int l, input int c, input int it, input int f);
        ent_t e;
        e.sf    = 4'(sf);
        e.layer = 2'(l);
        e.col   = 3'(c);
        e.iter  = 4'(it);
        e.flush = 1'(f);
        return e;
    endfunction

    function automatic ent_t cur_ent();
        return mk(int'(bus.shift_factor), int'(bus.layer_idx), int'(bus.col_idx),
                  int'(bus.iter_idx), int'(bus.flush));
    endfunction

    function automatic ent_t ent_at(input int i);
        if (i < acc.size()) return acc[i];
        return '1;
    endfunction

    // Reference walk: relative shift against the last accepted value per column.
    function automatic void build_expected(input int iters);
        int rot [8];
        int n;
        exp_q.delete();
        n = (iters == 0) ? 1 : iters;
        for (int c = 0; c < 8; c++) rot[c] = 0;
        for (int it = 0; it < n; it++)
            for (int l = 0; l < 4; l++)
                for (int c = 0; c < 8; c++) begin
                    int s;
                    s = tm[l*8 + c];
                    if (s != 15) begin
                        exp_q.push_back(mk((s - rot[c] + 15) % 15, l, c, it, 0));
                        rot[c] = s;
                    end
                end
        for (int c = 0; c < 8; c++)
            if (rot[c] != 0) exp_q.push_back(mk(15 - rot[c], 0, c, n - 1, 1));
    endfunction

    task automatic compare_seq(input string tag);
        check({tag, "_count"}, 32'(acc.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < acc.size(); i++)
            check($sformatf("%s_%0d", tag, i), 32'(acc[i]), 32'(exp_q[i]));
    endtask

    task automatic write_entry(input int a, input int d);
        cfg_we   = 1'b1;
        cfg_addr = 5'(a);
        cfg_data = 4'(d);
        tick();
        cfg_we   = 1'b0;
        tm[a]    = d;
    endtask

    // k counts cycles after the one in which start is high; inj_kind 1 = cfg+start, 2 = rst.
    task automatic run_sched(input int iters, input bit rand_rdy, input int inj_k, input int inj_kind,
                             input bit cfg_at_start, input int ca, input int cd,
                             output int done_k, output int stalls);
        int   k;
        bit   have_prev;
        bit   rdy;
        ent_t cur;
        ent_t prev;
        acc.delete();
        max_iter  = 0;
        any_valid = 0;
        stab_err  = 0;
        done_k    = -1;
        stalls    = 0;
        have_prev = 0;
        prev      = '0;
        k         = 0;
        iter_num  = 4'(iters);
        bus.out_ready = 1'b1;
        start     = 1'b1;
        if (cfg_at_start) begin
            cfg_we   = 1'b1;
            cfg_addr = 5'(ca);
            cfg_data = 4'(cd);
            tm[ca]   = cd;
        end
        while (done_k < 0 && k < 1000) begin
            tick();
            k++;
            if (k == 1) begin
                start  = 1'b0;
                cfg_we = 1'b0;
                check("busy_rise", 32'(busy), 32'd1);
            end
            if (inj_kind != 0 && k == inj_k + 1) begin
                start  = 1'b0;
                cfg_we = 1'b0;
                if (inj_kind == 2) begin
                    check("rst_valid", 32'(bus.out_valid), 32'd0);
                    check("rst_busy", 32'(busy), 32'd0);
                    rst = 1'b0;
                    bus.out_ready = 1'b1;
                    return;
                end
            end
            cur = cur_ent();
            if (have_prev && (!bus.out_valid || cur != prev)) stab_err++;
            if (bus.out_valid) begin
                any_valid = 1;
                if (int'(bus.iter_idx) > max_iter) max_iter = int'(bus.iter_idx);
            end
            if (done) begin
                done_k = k;
                check("busy_at_done", 32'(busy), 32'd0);
            end
            rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.out_ready = rdy;
            if (bus.out_valid) begin
                if (rdy) acc.push_back(cur);
                else stalls++;
            end
            have_prev = bus.out_valid && !rdy;
            prev      = cur;
            if (inj_kind == 1 && k == inj_k) begin
                cfg_we   = 1'b1;
                cfg_addr = 5'd0;
                cfg_data = 4'd5;
                start    = 1'b1;
            end
            if (inj_kind == 2 && k == inj_k) rst = 1'b1;
        end
        bus.out_ready = 1'b1;
        if (done_k < 0) check("done_timeout", 32'(k), 32'd0);
        tick();
    endtask

    initial begin
        int dk;
        int st;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_shift", 32'(bus.shift_factor), 32'd0);
        check("rst_layer", 32'(bus.layer_idx), 32'd0);
        check("rst_col", 32'(bus.col_idx), 32'd0);
        check("rst_iter", 32'(bus.iter_idx), 32'd0);
        check("rst_flush", 32'(bus.flush), 32'd0);
        check("rst_busy0", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();

        // All-null table: no output at all, two full iterations plus flush.
        for (int a = 0; a < 32; a++) write_entry(a, 15);
        run_sched(2, 0, 0, 0, 0, 0, 0, dk, st);
        check("null_any_valid", 32'(any_valid), 32'd0);
        check("null_acc", 32'(acc.size()), 32'd0);
        check("null_done_cyc", 32'(dk), 32'd73);

        // Column 0 only: 12, 3, null, 7.
        write_entry(0, 12);
        write_entry(8, 3);
        write_entry(24, 7);
        run_sched(1, 0, 0, 0, 0, 0, 0, dk, st);
        check("t1_sf0", 32'(ent_at(0).sf), 32'd12);
        check("t1_sf1", 32'(ent_at(1).sf), 32'd6);
        check("t1_layer1", 32'(ent_at(1).layer), 32'd1);
        check("t1_sf2", 32'(ent_at(2).sf), 32'd4);
        check("t1_layer2", 32'(ent_at(2).layer), 32'd3);
        check("t1_sf3", 32'(ent_at(3).sf), 32'd8);
        check("t1_flush3", 32'(ent_at(3).flush), 32'd1);
        check("t1_count", 32'(acc.size()), 32'd4);
        check("t1_done_cyc", 32'(dk), 32'd41);
        check("t1_done_pulse", 32'(done), 32'd0);

        // iter_num = 0 runs a single iteration.
        run_sched(0, 0, 0, 0, 0, 0, 0, dk, st);
        build_expected(0);
        compare_seq("t4");
        check("t4_max_iter", 32'(max_iter), 32'd0);
        check("t4_done_cyc", 32'(dk), 32'd41);

        // Richer table over two iterations, then the same under backpressure.
        write_entry(1, 5);
        write_entry(3, 14);
        write_entry(9, 9);
        write_entry(11, 0);
        write_entry(21, 1);
        write_entry(25, 5);
        write_entry(29, 13);
        build_expected(2);
        run_sched(2, 0, 0, 0, 0, 0, 0, dk, st);
        compare_seq("t3a");
        check("t3a_done_cyc", 32'(dk), 32'd73);
        run_sched(2, 1, 0, 0, 0, 0, 0, dk, st);
        compare_seq("t3b");
        check("t3b_done_cyc", 32'(dk), 32'(73 + st));
        check("t3b_stable", 32'(stab_err), 32'd0);

        // Write and second start mid-run are both ignored.
        build_expected(1);
        run_sched(1, 0, 10, 1, 0, 0, 0, dk, st);
        compare_seq("t5run");
        check("t5_done_cyc", 32'(dk), 32'd41);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_idle_busy", 32'(busy), 32'd0);
        end
        run_sched(1, 0, 0, 0, 0, 0, 0, dk, st);
        compare_seq("t5rb");
        check("t5_first_sf", 32'(ent_at(0).sf), 32'd12);

        // Reset mid-RUN, then a clean restart from rot = 0.
        run_sched(1, 0, 5, 2, 0, 0, 0, dk, st);
        run_sched(1, 0, 0, 0, 0, 0, 0, dk, st);
        compare_seq("t6");
        check("t6_first_raw", 32'(ent_at(0).sf), 32'd12);
        check("t6_done_cyc", 32'(dk), 32'd41);

        // Write together with start in IDLE is used by the schedule.
        run_sched(1, 0, 0, 0, 1, 0, 9, dk, st);
        build_expected(1);
        compare_seq("t7");
        check("t7_first_sf", 32'(ent_at(0).sf), 32'd9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/qsn_shift_scheduler.md
# qsn_shift_scheduler

Sequences shift factors into the length-15 QSN controller for layered LDPC decoding. Holds a programmable base-matrix shift table and walks it iteration by iteration, layer by layer, column by column. For every non-null submatrix it issues the shift *relative to that column's current stored rotation*. After the last iteration it emits restoring shifts so the column memories return to natural order.

## Interface
- PERMUTATION_LENGTH, 15, circulant size Pc; legal shifts 0..Pc-1.
- SHIFT_W, 4, shift width, $clog2(PERMUTATION_LENGTH).
- LAYER_NUM, 4, base-matrix rows (layers).
- COL_NUM, 8, base-matrix block columns.
- ITER_W, 4, width of iteration count.

Ports (one clock; reset is synchronous and active-high):
- sys_clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- cfg_we  in  1  shift-table write strobe.
- cfg_addr  in  $clog2(LAYER_NUM*COL_NUM)  entry index, layer*COL_NUM+col.
- cfg_data  in  SHIFT_W  shift value; 4'hF = null submatrix.
- start  in  1  begin decode schedule.
- iter_num  in  ITER_W  iterations to run; latched on start; 0 treated as 1.
- out_ready  in  1  downstream (QSN controller/datapath) accepts the current shift.
- out_valid  out  1  shift_factor and tags valid.
- shift_factor  out  SHIFT_W  relative shift to the QSN controller, 0..Pc-1.
- layer_idx  out  $clog2(LAYER_NUM)  layer of current entry.
- col_idx  out  $clog2(COL_NUM)  column of current entry.
- iter_idx  out  ITER_W  current iteration, 0-based.
- flush  out  1  current entry is a restoring shift.
- busy  out  1  schedule in progress.
- done  out  1  one-cycle pulse at schedule completion.

## Operation
- States:
  - IDLE: start → RUN. Pointers cleared; rotation registers rot[0..COL_NUM-1] cleared to 0.
  - RUN: after the last column of the last layer of the last iteration → FLUSH.
  - FLUSH: after column COL_NUM-1 → DONE.
  - DONE: unconditionally → IDLE next cycle.
- RUN scans one (layer, col) slot per cycle: col 0..COL_NUM-1, then layer+1; after LAYER_NUM-1, layer wraps to 0 and iter_idx increments.
- Non-null slot with entry s:
  - out_valid=1, shift_factor=(s − rot[col]) mod Pc, computed as s−rot if s≥rot, else s+Pc−rot.
  - On acceptance, rot[col] ← s.
- Null slot (4'hF) produces no output, consumes one cycle, and leaves rot unchanged.
- FLUSH scans col 0..COL_NUM-1:
  - rot[col]≠0: emit shift_factor=Pc−rot[col] with flush=1; on acceptance rot[col] ← 0.
  - rot[col]=0: skip.
  - flush=1, layer_idx=0, iter_idx=last iteration.
- Handshake:
  - Valid/ready. Once out_valid is high, all outputs are held stable until out_valid&&out_ready.
  - The pointer advances only on acceptance or on a skipped slot.
- Configuration:
  - cfg_we is honoured only in IDLE; it is ignored while busy.
  - Out-of-range addresses are ignored.
  - Table values 15 (when Pc=15) are null; values ≥Pc are otherwise undefined and must not be written.
- start is ignored while busy. start together with cfg_we in IDLE: the write completes and the schedule uses the new value.
- rst: returns to IDLE and clears rot, pointers and outputs. The shift table is not reset (contents retained).

## Timing
- Reset values: out_valid=0, shift_factor=0, layer_idx=0, col_idx=0, iter_idx=0, flush=0, busy=0, done=0.
- All outputs are registered.
- First slot is presented the cycle after start is sampled; busy rises the same cycle.
- One slot per cycle with out_ready held high.
- Total latency start→done with always-ready: iter_num·LAYER_NUM·COL_NUM + COL_NUM + 1 cycles.
- Each out_ready-low cycle on a valid slot adds one cycle.
- done pulses in the DONE cycle, and busy falls in the same cycle.
- The rot update for an accepted slot is visible to the next slot of the same column. This is at minimum COL_NUM cycles later, so no forwarding is needed.

## Structure
- Package qsn_sched_pkg:
  - PERMUTATION_LENGTH, SHIFT_W, NULL_SHIFT=4'hF.
  - state enum {IDLE, RUN, FLUSH, DONE}.
- Sub-module qsn_shift_delta_modp: combinational (a − b) mod Pc subtractor, reused for RUN deltas (a=s, b=rot) and FLUSH (a=0, b=rot).
- Shift table: a LAYER_NUM·COL_NUM×SHIFT_W register array.

## Test plan
- Table col0 shifts {layer0:12, layer1:3, layer2:null, layer3:7}, iter_num=1, ready=1 → col0 outputs 12, 6, 4, then flush 8; done at cycle 4·8+8+1=41.
- All entries null, iter_num=2 → no out_valid for the whole run; done after 2·32+8+1=73 cycles.
- Random out_ready backpressure → outputs stable while valid&&!ready; accepted sequence identical to the always-ready run.
- iter_num=0 → behaves exactly as iter_num=1; iter_idx never exceeds 0.
- cfg_we and a second start issued mid-run → both ignored; table readback after done shows the old values.
- rst asserted mid-RUN → next cycle out_valid=0, busy=0; a subsequent start restarts from layer 0 with rot=0, so the first delta equals the raw shift.
